// File: rtl/seq_div32.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient
// bit per clock, followed by a single sign-fix cycle. Result after WIDTH+1 edges.
module seq_div32 #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             Busy,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Div_By_Zero,
    output logic             Result_Valid,
    output logic [1:0]       Dbg_State
);

    // Handshake: Start is accepted only on an edge where Busy=0 (IDLE); operands are
    // captured on that edge only. Busy stays high until the edge that raises
    // Result_Valid for one cycle; Start is ignored while Busy=1.

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;     // dividend magnitude, quotient bits shift in from the right
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rmd_q, rmd_d;
    logic               dbz_q, dbz_d;
    logic               valid_q, valid_d;

    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   trial;
    logic               trial_ok;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            zero_q   <= 1'b0;
            quo_q    <= '0;
            rmd_q    <= '0;
            dbz_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            zero_q   <= zero_d;
            quo_q    <= quo_d;
            rmd_q    <= rmd_d;
            dbz_q    <= dbz_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        zero_d    = zero_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dbz_d     = dbz_q;
        valid_d   = 1'b0;

        // Remainder never exceeds the divisor, so the bit shifted out of rem_q is always 0.
        rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
        trial     = {1'b0, rem_shift} - {2'b00, dvs_q};
        trial_ok  = ~trial[WIDTH+1];

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    dvd_d    = in_a[WIDTH-1] ? -in_a : in_a;
                    dvs_d    = in_b[WIDTH-1] ? -in_b : in_b;
                    sign_a_d = in_a[WIDTH-1];
                    sign_b_d = in_b[WIDTH-1];
                    zero_d   = (in_b == '0);
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = trial_ok ? trial[WIDTH:0] : rem_shift;
                dvd_d = {dvd_q[WIDTH-2:0], trial_ok};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // A zero divisor yields all-ones from the restoring loop anyway; force it so
                // the sign fix cannot disturb it. The remainder then rebuilds in_a.
                if (zero_q) begin
                    quo_d = '1;
                end else begin
                    quo_d = (sign_a_q ^ sign_b_q) ? -dvd_q : dvd_q;
                end
                rmd_d   = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                dbz_d   = zero_q;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign Busy         = (state_q != S_IDLE);
    assign Quotient     = quo_q;
    assign Remainder    = rmd_q;
    assign Div_By_Zero  = dbz_q;
    assign Result_Valid = valid_q;
    assign Dbg_State    = state_q;

endmodule

// File: tb/tb_seq_div32.sv
// Self-checking bench for seq_div32: directed and random divisions scored against a
// signed-division model through an expected-result queue.
module tb_seq_div32;

    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           busy;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           result_valid;
    logic [1:0]     dbg_state;

    logic [2*W:0]   exp_q[$];
    int             n_checks = 0;
    int             n_errors = 0;

    seq_div32 #(.WIDTH(W)) dut (
        .CLK          (clk),
        .RST          (rst_n),
        .Start        (start),
        .in_a         (in_a),
        .in_b         (in_b),
        .Busy         (busy),
        .Quotient     (quotient),
        .Remainder    (remainder),
        .Div_By_Zero  (div_by_zero),
        .Result_Valid (result_valid),
        .Dbg_State    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W-1:0] sa, sb, q, r;
        logic [W-1:0] min_val;
        min_val = {1'b1, {(W-1){1'b0}}};
        sa = a;
        sb = b;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        if (a == min_val && b == {W{1'b1}}) return {1'b0, min_val, {W{1'b0}}};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, q, r};
    endfunction

    // driver: called on a falling edge; Start is seen by the next rising edge (E0)
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        in_a  = a;
        in_b  = b;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
        in_a  = $urandom;
        in_b  = $urandom;
        check_eq("busy_after_start", {{(2*W){1'b0}}, busy}, 1);
    endtask

    // monitor/scoreboard: edges_done = rising edges after E0 already elapsed
    task automatic wait_result(input int edges_done, input bit check_pulse);
        int edges;
        bit seen;
        logic [2*W:0] exp;
        edges = edges_done;
        seen  = 1'b0;
        for (int i = 0; i < W + 10 && !seen; i++) begin
            @(negedge clk);
            edges++;
            if (result_valid) seen = 1'b1;
        end
        check_eq("result_valid_seen", {{(2*W){1'b0}}, result_valid}, 1);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        else exp = 'x;
        check_eq("latency", edges, W + 1);
        check_eq("result", {div_by_zero, quotient, remainder}, exp);
        check_eq("busy_cleared", {{(2*W){1'b0}}, busy}, 0);
        if (check_pulse) begin
            @(negedge clk);
            check_eq("rv_single_pulse", {{(2*W){1'b0}}, result_valid}, 0);
            check_eq("result_held", {div_by_zero, quotient, remainder}, exp);
        end
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b);
        do_start(a, b);
        wait_result(0, 1'b1);
    endtask

    initial begin
        int rv_count;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0;
        start = 1'b0;
        in_a  = '0;
        in_b  = '0;
        #1;
        check_eq("reset_outputs", {div_by_zero, quotient, remainder}, '0);
        check_eq("reset_flags", {{(2*W-3){1'b0}}, busy, result_valid, dbg_state}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_one(32'd100, 32'd7);
        run_one(-32'sd100, 32'd7);
        run_one(32'd100, -32'sd7);
        run_one(-32'sd100, -32'sd7);
        run_one(32'h8000_0000, 32'hFFFF_FFFF);
        run_one(32'd5, 32'd0);
        run_one(-32'sd5, 32'd0);
        run_one(32'h8000_0000, 32'd1);
        run_one(32'h8000_0000, 32'd2);
        run_one(32'h8000_0000, 32'h8000_0000);
        run_one(32'd0, 32'd5);
        run_one(32'd7, 32'd100);
        run_one(32'h7FFF_FFFF, 32'h8000_0000);

        // Start re-asserted mid-division is ignored; then a back-to-back start
        do_start(32'd1000, 32'd33);
        repeat (4) @(negedge clk);
        start = 1'b1;
        in_a  = 32'd77;
        in_b  = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_result(5, 1'b0);
        do_start(32'd123456, -32'sd789);
        wait_result(0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 2) == 0) rb = W'($urandom_range(1, 20));
            else rb = $urandom;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            run_one(ra, rb);
        end

        // reset in the middle of a division
        do_start(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midreset_outputs", {div_by_zero, quotient, remainder}, '0);
        check_eq("midreset_flags", {{(2*W-3){1'b0}}, busy, result_valid, dbg_state}, 0);
        exp_q.delete();
        rv_count = 0;
        repeat (3) begin
            @(negedge clk);
            if (result_valid) rv_count++;
        end
        rst_n = 1'b1;
        repeat (W + 4) begin
            @(negedge clk);
            if (result_valid) rv_count++;
        end
        check_eq("no_rv_after_abort", rv_count, 0);
        run_one(32'd9, 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_div32.md
SEQ_DIV32 -- requirements
Module: seq_div32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand, quotient and remainder width in bits.
REQ-002 SHALL have port CLK  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port Start  input  1  request; sampled only while the block is idle.
REQ-005 SHALL have port in_a  input  WIDTH  signed dividend, two's complement.
REQ-006 SHALL have port in_b  input  WIDTH  signed divisor, two's complement.
REQ-007 SHALL have port Busy  output  1  high while a division is in progress.
REQ-008 SHALL have port Quotient  output  WIDTH  signed quotient, registered.
REQ-009 SHALL have port Remainder  output  WIDTH  signed remainder, registered.
REQ-010 SHALL have port Div_By_Zero  output  1  registered flag qualifying the current result.
REQ-011 SHALL have port Result_Valid  output  1  single-cycle pulse marking a new result.

Function
REQ-012 SHALL implement the states IDLE, DIV and FIX, with a cycle counter of at least ceil(log2(WIDTH+1)) bits.
REQ-013 SHALL, in IDLE with Start=1 at edge E0: capture |in_a|, |in_b|, both sign bits and a divisor-zero flag; clear the partial remainder; zero the counter; enter DIV; set Busy=1.
REQ-014 SHALL ignore Start in DIV and FIX; in_a and in_b need not be held after E0.
REQ-015 SHALL, in DIV, perform one restoring step per edge on magnitudes (WIDTH+1-bit remainder): shift in the next dividend MSB, trial-subtract the divisor, keep the difference and set quotient bit=1 if non-negative, else restore and set bit=0.
REQ-016 SHALL leave DIV for FIX after exactly WIDTH DIV edges (edges E1..E_WIDTH).
REQ-017 SHALL, in FIX at edge E_WIDTH+1: apply sign correction; load Quotient, Remainder and Div_By_Zero; pulse Result_Valid=1; clear Busy; return to IDLE.
REQ-018 SHALL therefore present a result at edge E0+WIDTH+1, with Result_Valid high for exactly one cycle.
REQ-019 SHALL truncate toward zero: Quotient is negated when the operand signs differ, and Remainder carries the sign of the dividend, so a*b... i.e. Quotient*in_b + Remainder = in_a (mod 2^WIDTH).
REQ-020 SHALL, for in_b=0: set Quotient to all ones, Remainder to in_a and Div_By_Zero=1, with the same latency.
REQ-021 SHALL, for in_a=-2^(WIDTH-1) and in_b=-1: set Quotient=-2^(WIDTH-1) (wrap-around), Remainder=0 and Div_By_Zero=0.
REQ-022 SHALL handle the magnitude of -2^(WIDTH-1) correctly as an unsigned WIDTH-bit value.
REQ-023 SHALL hold Quotient, Remainder and Div_By_Zero stable between results.
REQ-024 SHALL accept a new Start in the cycle after Result_Valid (back-to-back, edge E0+WIDTH+2).

Reset
REQ-025 SHALL, while RST=0 and regardless of the clock: force state=IDLE, Busy=0, Result_Valid=0, Quotient=0, Remainder=0, Div_By_Zero=0 and all internal registers to 0.
REQ-026 SHALL abort any in-flight division on reset with no Result_Valid pulse; the first Start after RST returns high SHALL be serviced normally.

Verification
REQ-027 SHALL cover in_a=100, in_b=7 -> Quotient=14, Remainder=2, Div_By_Zero=0, Result_Valid exactly WIDTH+1 edges after Start.
REQ-028 SHALL cover in_a=-100, in_b=7 -> Quotient=0xFFFFFFF2 (-14), Remainder=0xFFFFFFFE (-2); and in_a=100, in_b=-7 -> Quotient=-14, Remainder=2.
REQ-029 SHALL cover in_a=0x80000000, in_b=0xFFFFFFFF -> Quotient=0x80000000, Remainder=0, Div_By_Zero=0.
REQ-030 SHALL cover in_a=5, in_b=0 -> Quotient=0xFFFFFFFF, Remainder=5, Div_By_Zero=1.
REQ-031 SHALL cover Start re-asserted with new operands at E5 while Busy -> ignored, first result unchanged; then back-to-back Start at E0+WIDTH+2 -> second correct result.
REQ-032 SHALL cover RST driven low mid-DIV at E10 -> all outputs 0 immediately, no Result_Valid; a new Start with 9/3 after release -> Quotient=3, Remainder=0.
